// File: rtl/table_sequencer.sv
// Remote-mode table playback: on each trigger pops one line from the DDS table FIFOs,
// hands it to the DDS writer over req/ack, then dwells for that line's TIME entry.
module table_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NFIFO       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigIn,
    input  logic             softTrig,
    input  logic [1:0]       rcontrol,
    input  logic [9:0]       rlines,
    input  logic [NFIFO-1:0] fifoEmpty,
    input  logic [31:0]      timeQ,
    input  logic             ddsAck,
    output logic [NFIFO-1:0] rdReq,
    output logic             ddsReq,
    output logic [9:0]       lineIdx,
    output logic             busy,
    output logic             tableDone,
    output logic             trigOverrun
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        POP   = 3'd2,
        LATCH = 3'd3,
        WRITE = 3'd4,
        DWELL = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t           state_r;
    logic [SYNC_N:0]  sync_r;
    logic             ext_trig_r;
    logic             table_mode_r;
    logic [31:0]      dwell_r;

    logic             trig_s;
    logic             table_end_s;
    logic [9:0]       line_next_s;
    logic [31:0]      dwell_load_s;
    logic [NFIFO-1:0] pop_mask_s;

    // trigIn synchronizer; the top bit is a delayed copy used for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r     <= '0;
            ext_trig_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_N-1:0], trigIn};
            ext_trig_r <= sync_r[SYNC_N-1] & ~sync_r[SYNC_N];
        end
    end

    // combined trigger and next-line helpers
    always_comb begin
        trig_s       = softTrig | ext_trig_r;
        pop_mask_s   = ~fifoEmpty;
        table_end_s  = (lineIdx >= rlines) | fifoEmpty[NFIFO-1];
        line_next_s  = lineIdx;
        dwell_load_s = timeQ;
        if (lineIdx != 10'd1023) begin
            line_next_s = lineIdx + 10'd1;
        end else begin
            line_next_s = lineIdx;
        end
        if (timeQ == 32'd0) begin
            dwell_load_s = 32'd1;
        end else begin
            dwell_load_s = timeQ;
        end
    end

    // sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            table_mode_r <= 1'b0;
            dwell_r      <= 32'd0;
            rdReq        <= '0;
            ddsReq       <= 1'b0;
            lineIdx      <= 10'd0;
            busy         <= 1'b0;
            tableDone    <= 1'b0;
            trigOverrun  <= 1'b0;
        end else begin
            rdReq       <= '0;
            tableDone   <= 1'b0;
            trigOverrun <= trig_s & (state_r != ARM);
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    if (rcontrol != 2'b00) begin
                        state_r <= ARM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARM: begin
                    if (trig_s) begin
                        // reserved mode 11 behaves as whole-table mode
                        table_mode_r <= rcontrol[1];
                        busy         <= 1'b1;
                        if (table_end_s) begin
                            state_r   <= DONE;
                            tableDone <= 1'b1;
                        end else begin
                            state_r <= POP;
                            rdReq   <= pop_mask_s;
                        end
                    end else if (rcontrol == 2'b00) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ARM;
                    end
                end
                POP: begin
                    state_r <= LATCH;
                end
                LATCH: begin
                    dwell_r <= dwell_load_s;
                    ddsReq  <= 1'b1;
                    state_r <= WRITE;
                end
                WRITE: begin
                    if (ddsAck) begin
                        ddsReq  <= 1'b0;
                        lineIdx <= line_next_s;
                        if (rcontrol == 2'b00) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            dwell_r <= 32'd0;
                        end else begin
                            state_r <= DWELL;
                        end
                    end else begin
                        state_r <= WRITE;
                    end
                end
                DWELL: begin
                    if (rcontrol == 2'b00) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        dwell_r <= 32'd0;
                    end else if (dwell_r <= 32'd1) begin
                        dwell_r <= 32'd0;
                        if (!table_mode_r) begin
                            state_r <= ARM;
                            busy    <= 1'b0;
                        end else if (table_end_s) begin
                            state_r   <= DONE;
                            tableDone <= 1'b1;
                        end else begin
                            state_r <= POP;
                            rdReq   <= pop_mask_s;
                        end
                    end else begin
                        dwell_r <= dwell_r - 32'd1;
                    end
                end
                DONE: begin
                    lineIdx <= 10'd0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    ddsReq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_table_sequencer.sv
// Scoreboard bench for table_sequencer: expected lines (index, read mask, dwell) are queued
// when a trigger is issued and checked as the DUT hands each line to the DDS writer model.
module tb_table_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigIn = 1'b0;
    logic        softTrig = 1'b0;
    logic [1:0]  rcontrol = 2'b00;
    logic [9:0]  rlines = 10'd0;
    logic [6:0]  fifoEmpty = 7'h00;
    logic [31:0] timeQ = 32'd0;
    logic        ddsAck = 1'b0;
    logic [6:0]  rdReq;
    logic        ddsReq;
    logic [9:0]  lineIdx;
    logic        busy;
    logic        tableDone;
    logic        trigOverrun;

    table_sequencer #(.SYNC_STAGES(2), .NFIFO(7)) dut (
        .clk(clk), .rst(rst), .trigIn(trigIn), .softTrig(softTrig),
        .rcontrol(rcontrol), .rlines(rlines), .fifoEmpty(fifoEmpty),
        .timeQ(timeQ), .ddsAck(ddsAck), .rdReq(rdReq), .ddsReq(ddsReq),
        .lineIdx(lineIdx), .busy(busy), .tableDone(tableDone),
        .trigOverrun(trigOverrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [6:0] mask;
        int         dwell;
    } line_t;

    line_t       exp_q[$];
    logic [31:0] tq[$];
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 1;
    int          wcnt = 0;
    int          done_cnt = 0;
    int          ovr_cnt = 0;
    int          pop_cnt = 0;
    int          dcnt = 0;
    logic        prev_req = 1'b0;
    logic        in_dwell = 1'b0;
    logic [6:0]  last_mask = 7'h00;
    line_t       cur;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_line(input int idx, input logic [6:0] mask, input logic [31:0] tval, input int dw);
        line_t l;
        l.idx = idx;
        l.mask = mask;
        l.dwell = dw;
        exp_q.push_back(l);
        tq.push_back(tval);
    endtask

    task automatic soft_trig();
        @(posedge clk); #1 softTrig = 1'b1;
        @(posedge clk); #1 softTrig = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        check_val("wait_idle", busy, 0);
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ddsReq && n < 50);
        check_val("wait_req", ddsReq, 1);
    endtask

    // TIME FIFO model: next entry appears once rdReq[6] is seen
    always @(negedge clk) begin
        if (rdReq[6]) begin
            if (tq.size() > 0) timeQ = tq.pop_front();
            else timeQ = 32'd7;
        end
    end

    // DDS writer model: acks ack_delay cycles into a request
    always @(negedge clk) begin
        if (ddsAck) ddsAck = 1'b0;
        else if (ddsReq) begin
            wcnt++;
            if (wcnt >= ack_delay) begin
                ddsAck = 1'b1;
                wcnt = 0;
            end
        end else wcnt = 0;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rdReq != 7'h00) begin
            last_mask = rdReq;
            pop_cnt++;
        end
        if (tableDone) done_cnt++;
        if (trigOverrun) ovr_cnt++;
        if (ddsReq && !prev_req) begin
            if (exp_q.size() == 0) check_val("unexpected_line", 1, 0);
            else begin
                cur = exp_q.pop_front();
                check_val("line_idx", {22'd0, lineIdx}, cur.idx);
                check_val("line_mask", {25'd0, last_mask}, {25'd0, cur.mask});
            end
        end
        if (!ddsReq && prev_req) begin
            in_dwell = 1'b1;
            dcnt = 0;
        end
        if (in_dwell) begin
            if (rdReq != 7'h00 || tableDone || !busy || ddsReq) begin
                check_val("dwell", dcnt, cur.dwell);
                in_dwell = 1'b0;
            end else dcnt++;
        end
        prev_req = ddsReq;
    end

    initial begin
        int d0;
        int p0;
        int o0;
        // reset state
        repeat (2) @(negedge clk);
        check_val("rst_outputs", {rdReq, ddsReq, lineIdx, busy, tableDone, trigOverrun}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_outputs", {rdReq, ddsReq, lineIdx, busy, tableDone, trigOverrun}, 0);

        // step mode, three lines, dwell 5
        rcontrol = 2'b01; rlines = 10'd3; ack_delay = 1;
        for (int i = 0; i < 3; i++) expect_line(i, 7'h7f, 32'd5, 5);
        @(posedge clk); #1;
        soft_trig();
        @(negedge clk); check_val("pop_cycle", rdReq, 7'h7f);
        @(negedge clk); check_val("latch_cycle", {rdReq, ddsReq}, 0);
        @(negedge clk); check_val("req_latency", ddsReq, 1);
        wait_idle();
        for (int i = 1; i < 3; i++) begin
            soft_trig();
            wait_idle();
        end
        check_val("step_lineidx", lineIdx, 3);
        d0 = done_cnt;
        soft_trig();
        @(negedge clk); check_val("step_done", {rdReq, tableDone}, 1);
        @(negedge clk); check_val("step_idx_clr", {lineIdx, tableDone}, 0);
        check_val("step_done_cnt", done_cnt - d0, 1);

        // whole-table mode, dwell {1,2,3,1}, late acks
        rcontrol = 2'b10; rlines = 10'd4; ack_delay = 2;
        expect_line(0, 7'h7f, 32'd0, 1);
        expect_line(1, 7'h7f, 32'd2, 2);
        expect_line(2, 7'h7f, 32'd3, 3);
        expect_line(3, 7'h7f, 32'd1, 1);
        repeat (2) @(posedge clk);
        d0 = done_cnt;
        soft_trig();
        for (int n = 0; n < 300 && done_cnt == d0; n++) @(negedge clk);
        @(negedge clk); check_val("table_idx_clr", lineIdx, 0);
        repeat (3) @(negedge clk);
        check_val("table_done_cnt", done_cnt - d0, 1);

        // external trigger through the synchronizer, held high
        rcontrol = 2'b01; rlines = 10'd2; ack_delay = 1;
        expect_line(0, 7'h7f, 32'd3, 3);
        repeat (2) @(posedge clk);
        #1 trigIn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("trigin_lat", rdReq, (k == 4) ? 7'h7f : 7'h00);
        end
        wait_idle();
        p0 = pop_cnt;
        repeat (10) @(negedge clk);
        check_val("trigin_noretrig", pop_cnt - p0, 0);
        trigIn = 1'b0;

        // trigger during DWELL overruns
        expect_line(1, 7'h7f, 32'd6, 6);
        o0 = ovr_cnt;
        soft_trig();
        wait_req();
        do @(negedge clk); while (ddsReq);
        soft_trig();
        @(negedge clk); check_val("overrun_pulse", trigOverrun, 1);
        @(negedge clk); check_val("overrun_clear", trigOverrun, 0);
        wait_idle();
        check_val("overrun_cnt", ovr_cnt - o0, 1);
        check_val("overrun_idx", lineIdx, 2);

        // lineIdx == rlines, then TIME FIFO empty
        soft_trig();
        @(negedge clk); check_val("end_done", {rdReq, tableDone}, 1);
        @(negedge clk); check_val("end_idx", lineIdx, 0);
        fifoEmpty = 7'h40;
        repeat (2) @(posedge clk);
        soft_trig();
        @(negedge clk); check_val("empty_done", {rdReq, tableDone}, 1);
        fifoEmpty = 7'h10;

        // short sweep FIFO
        expect_line(0, 7'h6f, 32'd2, 2);
        repeat (2) @(posedge clk);
        soft_trig();
        @(negedge clk); check_val("short_mask", rdReq, 7'h6f);
        wait_idle();
        fifoEmpty = 7'h00;

        // rcontrol to 00 during WRITE: skip dwell, keep index
        ack_delay = 4;
        expect_line(1, 7'h7f, 32'd9, 0);
        soft_trig();
        wait_req();
        @(posedge clk); #1 rcontrol = 2'b00;
        wait_idle();
        check_val("off_idx", lineIdx, 2);
        p0 = pop_cnt;
        o0 = ovr_cnt;
        soft_trig();
        @(negedge clk); check_val("off_overrun", trigOverrun, 1);
        repeat (3) @(negedge clk);
        check_val("off_nopop", pop_cnt - p0, 0);

        // async reset mid-WRITE, then re-arm
        rcontrol = 2'b01; rlines = 10'd5; ack_delay = 10;
        expect_line(2, 7'h7f, 32'd4, 0);
        repeat (2) @(posedge clk);
        soft_trig();
        wait_req();
        @(posedge clk); #1 rst = 1'b1;
        #1 check_val("rst_drop_req", ddsReq, 0);
        @(negedge clk);
        check_val("rst_mid_outputs", {rdReq, ddsReq, lineIdx, busy, tableDone, trigOverrun}, 0);
        @(posedge clk); #1 rst = 1'b0; ack_delay = 1;
        expect_line(0, 7'h7f, 32'd1, 1);
        repeat (2) @(posedge clk);
        soft_trig();
        wait_idle();
        check_val("rearm_idx", lineIdx, 1);

        repeat (3) @(negedge clk);
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
